// File: rtl/keypad_pkg.sv
// Shared constants, FSM encoding and frame-capture record for the keypad scanner.
package keypad_pkg;

  localparam int KP_COLS   = 4;
  localparam int KP_ROWS   = 6;
  localparam int KP_COL_W  = $clog2(KP_COLS);
  localparam int KP_ROW_W  = $clog2(KP_ROWS);
  localparam int KP_CODE_W = 5;

  localparam logic [KP_CODE_W-1:0] KP_CODE_NONE = 5'd31;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REL_DB
  } kp_state_e;

  // Lowest key seen so far in the current frame.
  typedef struct packed {
    logic                 hit;
    logic [KP_CODE_W-1:0] code;
  } kp_scan_t;

endpackage

// File: rtl/keypad_col_sequencer.sv
// Column drive ring: holds each column low for SCAN_DIV cycles and flags the
// last dwell cycle (row sample point) and the last column's sample (frame end).
module keypad_col_sequencer
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 2500,
  parameter int COLS     = KP_COLS
) (
  input  logic                clk,
  input  logic                rst,
  output logic [COLS-1:0]     key_out,
  output logic [KP_COL_W-1:0] col_idx,
  output logic                sample_en,
  output logic                frame_end
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0]       DW_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [KP_COL_W-1:0] COL_LAST = KP_COL_W'(COLS - 1);

  logic [DW-1:0] dwell;

  assign sample_en = (dwell == DW_LAST);
  assign frame_end = sample_en && (col_idx == COL_LAST);

  // Dwell counter wraps on the sample cycle, which also steps the column ring.
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell   <= '0;
      col_idx <= '0;
      key_out <= {{(COLS-1){1'b1}}, 1'b0};
    end else if (sample_en) begin
      dwell   <= '0;
      col_idx <= (col_idx == COL_LAST) ? '0 : col_idx + 1'b1;
      key_out <= {key_out[COLS-2:0], key_out[COLS-1]};
    end else begin
      dwell   <= dwell + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x6 key matrix scanner: synchronises rows, captures the lowest key per frame,
// debounces press and release over DEBOUNCE_CNT frames and reports one code per press.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 2500,
  parameter int DEBOUNCE_CNT = 8,
  parameter int COLS         = KP_COLS,
  parameter int ROWS         = KP_ROWS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ROWS-1:0]      key_in,
  output logic [COLS-1:0]      key_out,
  output logic [KP_CODE_W-1:0] key_code,
  output logic                 key_valid,
  output logic                 key_held
);

  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [KP_COL_W-1:0] col_idx;
  logic                sample_en, frame_end;

  keypad_col_sequencer #(.SCAN_DIV(SCAN_DIV), .COLS(COLS)) u_seq (
    .clk       (clk),
    .rst       (rst),
    .key_out   (key_out),
    .col_idx   (col_idx),
    .sample_en (sample_en),
    .frame_end (frame_end)
  );

  // Two-flop row synchroniser; rows idle high. The sample point sits two cycles
  // after the column switch at the earliest, so the delayed rows still belong to it.
  logic [1:0][ROWS-1:0] key_sync;
  always_ff @(posedge clk) begin
    if (rst) key_sync <= '1;
    else     key_sync <= {key_sync[0], key_in};
  end

  // Lowest active (low) row of the currently driven column.
  logic                row_hit;
  logic [KP_ROW_W-1:0] row_sel;
  always_comb begin
    row_hit = 1'b0;
    row_sel = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (!key_sync[1][r]) begin
        row_hit = 1'b1;
        row_sel = KP_ROW_W'(r);
      end
    end
  end

  logic [KP_CODE_W-1:0] col_code;
  assign col_code = KP_CODE_W'(col_idx) * KP_CODE_W'(ROWS) + KP_CODE_W'(row_sel);

  // Columns arrive in ascending order, so the first hit of a frame is the lowest code.
  kp_scan_t best_q;
  always_ff @(posedge clk) begin
    if (rst || frame_end)
      best_q <= '{hit: 1'b0, code: KP_CODE_NONE};
    else if (sample_en && row_hit && !best_q.hit)
      best_q <= '{hit: 1'b1, code: col_code};
  end

  // Frame result includes the last column, whose sample coincides with frame_end.
  logic [KP_CODE_W-1:0] frame_res;
  assign frame_res = best_q.hit ? best_q.code : (row_hit ? col_code : KP_CODE_NONE);

  kp_state_e            state_q, state_d;
  logic [KP_CODE_W-1:0] cand_q, cand_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [KP_CODE_W-1:0] code_d;
  logic                 valid_d, held_d;

  // Debounce state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cand_q    <= KP_CODE_NONE;
      cnt_q     <= '0;
      key_code  <= KP_CODE_NONE;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      key_code  <= code_d;
      key_valid <= valid_d;
      key_held  <= held_d;
    end
  end

  // Debounce transitions, evaluated once per frame end.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    code_d  = key_code;
    valid_d = 1'b0;
    held_d  = key_held;
    if (frame_end) begin
      unique case (state_q)
        IDLE: begin
          if (frame_res != KP_CODE_NONE) begin
            cand_d  = frame_res;
            cnt_d   = CNT_ONE;
            state_d = PRESS_DB;
          end
        end
        PRESS_DB: begin
          if (frame_res == cand_q) begin
            if (cnt_q == CNT_LAST) begin
              code_d  = cand_q;
              valid_d = 1'b1;
              held_d  = 1'b1;
              state_d = HELD;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else if (frame_res == KP_CODE_NONE) begin
            state_d = IDLE;
          end else begin
            cand_d = frame_res;
            cnt_d  = CNT_ONE;
          end
        end
        HELD: begin
          if (frame_res == KP_CODE_NONE) begin
            cnt_d   = CNT_ONE;
            state_d = REL_DB;
          end
        end
        REL_DB: begin
          if (frame_res != KP_CODE_NONE) begin
            cnt_d   = '0;
            state_d = HELD;
          end else if (cnt_q == CNT_LAST) begin
            held_d  = 1'b0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Scoreboarded bench: per-frame key sets drive a matrix model; a frame-level
// reference decides accept/release events, which a monitor matches against DUT strobes.
module tb_keypad_matrix_scanner;

  localparam int SD = 4;
  localparam int DB = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] key_in;
  logic [3:0] key_out;
  logic [4:0] key_code;
  logic       key_valid, key_held;

  keypad_matrix_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .key_out   (key_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Physical matrix: a pressed key pulls its row low while its column is driven.
  logic [23:0] mask = '0;
  always_comb begin
    key_in = '1;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 6; r++)
        if (!key_out[c] && mask[c*6+r]) key_in[r] = 1'b0;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit       rel;
    logic [4:0] code;
    int       cyc;
  } ev_t;
  ev_t exp_q[$];

  // Reference state: recent frame results and the debounced key status.
  logic [4:0] hist[$];
  bit         m_held;
  logic [4:0] m_code;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [4:0] lowest(input logic [23:0] m);
    for (int i = 0; i < 24; i++) if (m[i]) return 5'(i);
    return 5'd31;
  endfunction

  // Monitor: every strobe or held fall must match the oldest expected event.
  logic held_q;
  ev_t  e;
  always @(negedge clk) begin
    if (key_valid === 1'b1 || (held_q === 1'b1 && key_held === 1'b0)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event valid=%0b held=%0b code=%0d cycle=%0d",
                 key_valid, key_held, key_code, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.rel != (key_valid !== 1'b1) || key_code !== e.code || cyc != e.cyc) begin
          bad++;
          $display("FAIL event actual rel=%0b code=%0d cycle=%0d required rel=%0b code=%0d cycle=%0d",
                   key_valid !== 1'b1, key_code, cyc, e.rel, e.code, e.cyc);
        end
      end
    end
    held_q <= key_held;
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    if (m_held) exp_q.push_back('{1'b1, 5'd31, cyc});
    m_held = 1'b0;
    m_code = 5'd31;
    hist.delete();
    check("rst_key_out", int'(key_out), 4'b1110);
    check("rst_key_code", int'(key_code), 31);
    check("rst_key_valid", int'(key_valid), 0);
    check("rst_key_held", int'(key_held), 0);
  endtask

  // One frame with a fixed set of pressed keys, then the reference decision.
  task automatic run_frame(input logic [23:0] m);
    logic [3:0] eo;
    logic [4:0] res;
    bit         same, acc;
    mask = m;
    for (int i = 0; i < 16; i++) begin
      eo = 4'b1111;
      eo[i/4] = 1'b0;
      check("key_out", int'(key_out), int'(eo));
      @(posedge clk); #1;
    end
    res = lowest(m);
    hist.push_back(res);
    if (hist.size() > DB) void'(hist.pop_front());
    same = (hist.size() == DB);
    foreach (hist[j]) if (hist[j] != res) same = 1'b0;
    acc = 1'b0;
    if (!m_held && same && res != 5'd31) begin
      acc    = 1'b1;
      m_held = 1'b1;
      m_code = res;
      exp_q.push_back('{1'b0, res, cyc});
    end else if (m_held && same && res == 5'd31) begin
      m_held = 1'b0;
      exp_q.push_back('{1'b1, m_code, cyc});
    end
    check("frame_valid", int'(key_valid), int'(acc));
    check("frame_held", int'(key_held), int'(m_held));
    check("frame_code", int'(key_code), int'(m_code));
  endtask

  localparam logic [23:0] K15 = 24'h1 << 15;

  initial begin
    logic [23:0] cur;
    int          r;
    m_held = 1'b0;
    m_code = 5'd31;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Idle scanning, no key
    for (int f = 0; f < 20; f++) run_frame('0);

    // Clean press of col2,row3 then release
    for (int f = 0; f < 3; f++) run_frame(K15);
    for (int f = 0; f < 3; f++) run_frame('0);

    // Bounce in frame 2 restarts debounce
    run_frame(K15); run_frame(K15); run_frame('0);
    for (int f = 0; f < 3; f++) run_frame(K15);
    for (int f = 0; f < 3; f++) run_frame('0);

    // Two simultaneous keys, then a third while held
    for (int f = 0; f < 3; f++) run_frame((24'h1 << 6) | (24'h1 << 5));
    for (int f = 0; f < 3; f++) run_frame((24'h1 << 6) | (24'h1 << 5) | (24'h1 << 18));
    for (int f = 0; f < 3; f++) run_frame('0);

    // Reset in the middle of press debounce
    run_frame(K15); run_frame(K15);
    do_reset();
    for (int f = 0; f < 3; f++) run_frame(K15);
    for (int f = 0; f < 3; f++) run_frame('0);

    // Randomised key activity
    cur = '0;
    for (int f = 0; f < 250; f++) begin
      r = int'($urandom_range(0, 9));
      if (r == 6 || r == 9) cur = '0;
      else if (r == 7) cur = 24'h1 << $urandom_range(0, 23);
      else if (r == 8) cur = (24'h1 << $urandom_range(0, 23)) | (24'h1 << $urandom_range(0, 23));
      run_frame(cur);
    end
    for (int f = 0; f < 3; f++) run_frame('0);

    repeat (2) @(posedge clk);
    #1;
    check("events_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
